fixed_map_update_module: RTL and testbench
==========================================

FIXED_MAP_UPDATE_MODULE -- requirements
Module: fixed_map_update_module

Interface
REQ-001 SHALL provide one clock and a synchronous, active-high reset:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
REQ-002 SHALL provide these ports:
- merge_req  input  1  landed-piece merge request, sampled only in IDLE.
- piece_map  input  360  landed-piece squares, same layout as fixed_square_map.
- clear_map  input  1  synchronous game-restart request.
- fixed_square_map  output  360  registered playfield map, consumed by the display stage.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in DONE.
- lines_cleared  output  3  full rows removed by the last merge (0..4), valid from DONE until the next merge completes.
- game_over  output  1  sticky loss flag.
- total_lines  output  16  cumulative cleared rows (see REQ-020).
REQ-003 SHALL use this map layout:
- Row r (0=top..13=bottom) occupies bits 20r..20r+19.
- Playfield columns 0..9 are bits 20r+5..20r+14.
- All other bits, including 359:280, SHALL always read 0.

Function
REQ-004 SHALL implement the FSM states IDLE, MERGE, SCAN, SHIFT and DONE.
REQ-005 IDLE, merge_req=1: SHALL latch piece_map masked to the playfield bits, go to MERGE, and drive busy high from the next cycle.
REQ-006 merge_req SHALL be ignored outside IDLE, with no queuing.
REQ-007 MERGE (1 cycle):
- map <= map | piece.
- If (map & piece) != 0 before the update, SHALL set game_over.
- SHALL set row index to 13, clear the line counter, and go to SCAN.
REQ-008 SCAN (1 cycle per row):
- If all 10 playfield bits of row r are set, SHALL go to SHIFT.
- Otherwise, if r=0, SHALL go to DONE; otherwise r <= r-1.
REQ-009 SHIFT (1 cycle):
- Rows r..1 SHALL take the previous content of row r-1, and row 0 SHALL become 0.
- SHALL increment the line counter (saturating at 4) and return to SCAN with r unchanged.
REQ-010 DONE (1 cycle):
- SHALL pulse done, load lines_cleared from the counter, and return to IDLE.
- If any row-0 playfield bit is set, SHALL set game_over.
REQ-011 Latency: merge_req accepted at cycle 0 -> done high at cycle 16+2k, where k is the number of cleared rows.
REQ-012 fixed_square_map SHALL change only in MERGE and SHIFT.
REQ-013 The state register SHALL be one-hot or encoded; unreachable encodings SHALL return to IDLE.

Reset
REQ-014 rst=1 SHALL, at the next edge, set the following:
- map = 0, FSM = IDLE, busy = 0, done = 0.
- lines_cleared = 0, game_over = 0, total_lines = 0.
REQ-015 rst asserted mid-operation (any state) SHALL abort the operation with no done pulse.
REQ-016 clear_map=1 SHALL behave as reset except that total_lines is preserved.
REQ-017 rst SHALL have priority over clear_map, and clear_map over merge_req or FSM activity in the same cycle.
REQ-018 While game_over=1, merge_req SHALL be ignored until rst or clear_map.

Configuration
REQ-019 Macro SCORE_COUNTER_EN selects the total_lines behaviour.
REQ-020 With SCORE_COUNTER_EN defined: total_lines SHALL add lines_cleared in the DONE cycle, saturating at 65535.
REQ-021 Without SCORE_COUNTER_EN: total_lines SHALL be tied to 0 and no counter logic is generated; the port remains present.

Verification
REQ-022 Single piece, no full row:
- Stimulus: empty map, merge_req with bits 265..268 set.
- Response: done at cycle 16, map = those 4 bits, lines_cleared=0.
REQ-023 Single full row:
- Stimulus: row 13 holds 9 bits (col 9 missing) plus row 12 col 0; merge piece = row 13 col 9.
- Response: done at cycle 18, lines_cleared=1, row 13 = only col 0 (bit 265), row 12 = 0.
REQ-024 Four full rows:
- Stimulus: rows 10..13 each one bit short; merge a vertical I piece filling the gaps.
- Response: done at cycle 24, lines_cleared=4, map all 0.
REQ-025 Overlap:
- Stimulus: merge a piece overlapping an existing bit.
- Response: game_over=1; next merge_req ignored (busy stays 0); clear_map -> map=0, game_over=0.
REQ-026 Reset and masking:
- Stimulus: rst during SHIFT.
- Response: next cycle map=0, IDLE, no done pulse.
- Stimulus: piece_map bit 0 set.
- Response: map bit 0 stays 0.
REQ-027 SCORE_COUNTER_EN:
- Stimulus: three merges clearing 1, 2 and 4 rows.
- Response: total_lines=7 with the macro defined, 0 without it.

Source files
------------

// File: rtl/fixed_map_update_module.sv
// Playfield map update: merges a landed piece, clears full rows bottom-up, flags loss.
// Optional cumulative line counter on total_lines when SCORE_COUNTER_EN is defined.
module fixed_map_update_module (
    input  logic         clk,
    input  logic         rst,
    input  logic         merge_req,
    input  logic [359:0] piece_map,
    input  logic         clear_map,
    output logic [359:0] fixed_square_map,
    output logic         busy,
    output logic         done,
    output logic [2:0]   lines_cleared,
    output logic         game_over,
    output logic [15:0]  total_lines
);

    localparam int unsigned ROWS   = 14;
    localparam int unsigned ROW_W  = 20;
    localparam int unsigned COL_LO = 5;
    localparam int unsigned COLS   = 10;
    localparam int unsigned MAP_W  = 360;

    function automatic logic [MAP_W-1:0] build_mask();
        logic [MAP_W-1:0] m;
        m = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            m[r*ROW_W + COL_LO +: COLS] = '1;
        end
        return m;
    endfunction

    localparam logic [MAP_W-1:0] PLAYFIELD_MASK = build_mask();

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MERGE = 3'd1,
        SCAN  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state;
    logic [MAP_W-1:0] piece_q;
    logic [3:0]       row_idx;
    logic [2:0]       line_cnt;

    logic [15:0]      row_full_vec;
    logic             row_full;
    logic             row0_occupied;
    logic [MAP_W-1:0] shifted_map;

    always_comb begin
        row_full_vec = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            row_full_vec[r] = &fixed_square_map[r*ROW_W + COL_LO +: COLS];
        end
    end

    assign row_full      = row_full_vec[row_idx];
    assign row0_occupied = |fixed_square_map[COL_LO +: COLS];

    // Rows 1..row_idx drop by one; rows below the cleared row keep their content.
    always_comb begin
        shifted_map = fixed_square_map;
        shifted_map[ROW_W-1:0] = '0;
        for (int unsigned i = 1; i < ROWS; i++) begin
            if (i <= 32'(row_idx)) begin
                shifted_map[i*ROW_W +: ROW_W] = fixed_square_map[(i-1)*ROW_W +: ROW_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_map) begin
            state            <= IDLE;
            fixed_square_map <= '0;
            piece_q          <= '0;
            row_idx          <= '0;
            line_cnt         <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            lines_cleared    <= '0;
            game_over        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (merge_req && !game_over) begin
                        piece_q <= piece_map & PLAYFIELD_MASK;
                        state   <= MERGE;
                        busy    <= 1'b1;
                    end
                end
                MERGE: begin
                    if (|(fixed_square_map & piece_q)) begin
                        game_over <= 1'b1;
                    end
                    fixed_square_map <= fixed_square_map | piece_q;
                    row_idx          <= 4'd13;
                    line_cnt         <= '0;
                    state            <= SCAN;
                end
                SCAN: begin
                    if (row_full) begin
                        state <= SHIFT;
                    end else if (row_idx == 4'd0) begin
                        state <= DONE;
                    end else begin
                        row_idx <= row_idx - 4'd1;
                    end
                end
                SHIFT: begin
                    fixed_square_map <= shifted_map;
                    if (line_cnt != 3'd4) begin
                        line_cnt <= line_cnt + 3'd1;
                    end
                    state <= SCAN;
                end
                DONE: begin
                    done          <= 1'b1;
                    lines_cleared <= line_cnt;
                    if (row0_occupied) begin
                        game_over <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SCORE_COUNTER_EN
    logic [16:0] total_sum;

    assign total_sum = {1'b0, total_lines} + {14'd0, line_cnt};

    always_ff @(posedge clk) begin
        if (rst) begin
            total_lines <= '0;
        end else if (!clear_map && state == DONE) begin
            total_lines <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
        end
    end
`else
    assign total_lines = '0;
`endif

endmodule

// File: tb/tb_fixed_map_update_module.sv
// Scoreboard bench for fixed_map_update_module: a row-compaction model predicts each merge.
module tb_fixed_map_update_module;

    logic         clk = 1'b0;
    logic         rst;
    logic         merge_req;
    logic [359:0] piece_map;
    logic         clear_map;
    logic [359:0] fixed_square_map;
    logic         busy;
    logic         done;
    logic [2:0]   lines_cleared;
    logic         game_over;
    logic [15:0]  total_lines;

    fixed_map_update_module dut (
        .clk              (clk),
        .rst              (rst),
        .merge_req        (merge_req),
        .piece_map        (piece_map),
        .clear_map        (clear_map),
        .fixed_square_map (fixed_square_map),
        .busy             (busy),
        .done             (done),
        .lines_cleared    (lines_cleared),
        .game_over        (game_over),
        .total_lines      (total_lines)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [359:0] map;
        logic [2:0]   lines;
        logic         go;
        int unsigned  lat;
    } exp_t;

    exp_t         sb_q[$];
    logic [359:0] model_map;
    logic         model_go;
    int unsigned  model_total;
    logic [359:0] pf_mask;
    int           vec_cnt = 0;
    int           err_cnt = 0;

    task automatic check_val(input string tag, input logic [359:0] got, input logic [359:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [359:0] bit_at(input int r, input int c);
        logic [359:0] v;
        v = '0;
        v[r*20 + 5 + c] = 1'b1;
        return v;
    endfunction

    // Predict the merge result by removing full rows and packing the rest toward the bottom.
    task automatic model_push(input logic [359:0] piece);
        logic [359:0] pm;
        logic [359:0] m;
        logic [19:0]  r;
        logic [19:0]  out_rows [14];
        logic         ov;
        int           dst;
        int unsigned  k;
        exp_t         e;
        pm  = piece & pf_mask;
        ov  = |(model_map & pm);
        m   = model_map | pm;
        dst = 13;
        k   = 0;
        for (int i = 0; i < 14; i++) out_rows[i] = '0;
        for (int src = 13; src >= 0; src--) begin
            r = m[src*20 +: 20];
            if (&r[14:5]) begin
                k++;
            end else begin
                out_rows[dst] = r;
                dst--;
            end
        end
        m = '0;
        for (int i = 0; i < 14; i++) m[i*20 +: 20] = out_rows[i];
        model_map = m;
        model_go  = model_go | ov | (|out_rows[0][14:5]);
        e.map   = m;
        e.lines = (k > 4) ? 3'd4 : 3'(k);
        e.go    = model_go;
        e.lat   = 16 + 2*k;
`ifdef SCORE_COUNTER_EN
        model_total = model_total + int'(e.lines);
        if (model_total > 65535) model_total = 65535;
`endif
        sb_q.push_back(e);
    endtask

    task automatic run_merge(input logic [359:0] piece);
        int unsigned n;
        exp_t e;
        @(negedge clk);
        merge_req = 1'b1;
        piece_map = piece;
        model_push(piece);
        @(negedge clk);
        merge_req = 1'b0;
        piece_map = '0;
        check_val("busy_after_accept", 360'(busy), 360'(1));
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (done) begin
            e = sb_q.pop_front();
            check_val("map", fixed_square_map, e.map);
            check_val("lines_cleared", 360'(lines_cleared), 360'(e.lines));
            check_val("game_over", 360'(game_over), 360'(e.go));
            check_val("latency", 360'(n), 360'(e.lat));
            check_val("busy_at_done", 360'(busy), 360'(0));
            @(negedge clk);
            check_val("done_pulse_width", 360'(done), 360'(0));
            check_val("total_lines", 360'(total_lines), 360'(model_total));
        end else begin
            check_val("done_timeout", 360'(0), 360'(1));
            sb_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_map   = '0;
        model_go    = 1'b0;
        model_total = 0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_map = 1'b1;
        @(negedge clk);
        clear_map = 1'b0;
        model_map = '0;
        model_go  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [359:0] p;
        logic         seen_busy;
        logic         seen_done;
        int unsigned  exp_total;

        pf_mask = '0;
        for (int r = 0; r < 14; r++)
            for (int c = 0; c < 10; c++) pf_mask |= bit_at(r, c);

        rst       = 1'b0;
        merge_req = 1'b0;
        piece_map = '0;
        clear_map = 1'b0;
        do_reset();

        check_val("reset_map", fixed_square_map, '0);
        check_val("reset_busy", 360'(busy), 360'(0));
        check_val("reset_done", 360'(done), 360'(0));
        check_val("reset_lines", 360'(lines_cleared), 360'(0));
        check_val("reset_game_over", 360'(game_over), 360'(0));
        check_val("reset_total", 360'(total_lines), 360'(0));

        // Single piece, no full row.
        p = '0;
        for (int b = 265; b <= 268; b++) p[b] = 1'b1;
        run_merge(p);
        check_val("single_piece_map", fixed_square_map, p);
        do_clear();

        // One full row: row 12 col 0 falls into row 13.
        p = bit_at(12, 0);
        for (int c = 0; c < 9; c++) p |= bit_at(13, c);
        run_merge(p);
        run_merge(bit_at(13, 9));
        check_val("one_row_map", fixed_square_map, bit_at(13, 0));
        check_val("one_row_lines", 360'(lines_cleared), 360'(1));
        do_clear();
        check_val("clear_map_map", fixed_square_map, '0);

        // Four full rows with a vertical I piece in column 4.
        p = '0;
        for (int r = 10; r < 14; r++)
            for (int c = 0; c < 10; c++)
                if (c != 4) p |= bit_at(r, c);
        run_merge(p);
        p = '0;
        for (int r = 10; r < 14; r++) p |= bit_at(r, 4);
        run_merge(p);
        check_val("four_rows_map", fixed_square_map, '0);
        check_val("four_rows_lines", 360'(lines_cleared), 360'(4));
        do_clear();

        // Two full rows, bringing the cleared total to 7.
        p = '0;
        for (int r = 12; r < 14; r++)
            for (int c = 1; c < 10; c++) p |= bit_at(r, c);
        run_merge(p);
        run_merge(bit_at(12, 0) | bit_at(13, 0));
`ifdef SCORE_COUNTER_EN
        exp_total = 7;
`else
        exp_total = 0;
`endif
        check_val("total_after_three", 360'(total_lines), 360'(exp_total));
        do_clear();
        check_val("total_kept_by_clear", 360'(total_lines), 360'(exp_total));

        // Overlap sets game_over and locks out further merges.
        run_merge(bit_at(13, 0));
        run_merge(bit_at(13, 0));
        check_val("overlap_game_over", 360'(game_over), 360'(1));
        @(negedge clk);
        merge_req = 1'b1;
        piece_map = bit_at(13, 5);
        @(negedge clk);
        merge_req = 1'b0;
        piece_map = '0;
        seen_busy = busy;
        seen_done = done;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen_busy |= busy;
            seen_done |= done;
        end
        check_val("locked_busy", 360'(seen_busy), 360'(0));
        check_val("locked_done", 360'(seen_done), 360'(0));
        check_val("locked_map", fixed_square_map, model_map);
        do_clear();
        check_val("clear_go_map", fixed_square_map, '0);
        check_val("clear_go_flag", 360'(game_over), 360'(0));

        // Piece reaching row 0 ends the game.
        run_merge(bit_at(0, 3));
        check_val("row0_game_over", 360'(game_over), 360'(1));
        do_clear();

        // Reset while in SHIFT aborts without a done pulse.
        p = '0;
        for (int c = 0; c < 9; c++) p |= bit_at(13, c);
        run_merge(p);
        @(negedge clk);
        merge_req = 1'b1;
        piece_map = bit_at(13, 9);
        @(negedge clk);
        merge_req = 1'b0;
        piece_map = '0;
        @(negedge clk);
        @(negedge clk);
        check_val("in_shift_busy", 360'(busy), 360'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_map   = '0;
        model_go    = 1'b0;
        model_total = 0;
        check_val("abort_map", fixed_square_map, '0);
        check_val("abort_busy", 360'(busy), 360'(0));
        check_val("abort_total", 360'(total_lines), 360'(0));
        seen_busy = busy;
        seen_done = done;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            seen_busy |= busy;
            seen_done |= done;
        end
        check_val("abort_no_done", 360'(seen_done), 360'(0));
        check_val("abort_idle", 360'(seen_busy), 360'(0));

        // Non-playfield bits are masked off.
        p = bit_at(13, 3);
        p[0]   = 1'b1;
        p[4]   = 1'b1;
        p[15]  = 1'b1;
        p[300] = 1'b1;
        p[359] = 1'b1;
        run_merge(p);
        check_val("mask_bit0", 360'(fixed_square_map[0]), 360'(0));
        check_val("mask_map", fixed_square_map, bit_at(13, 3));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
